change_dispenser: RTL

//  Downstream of the change serializer: receives the change amount as a 1-bit MSB-first frame,

---
 rtl/change_pkg.sv | 39 +++
 rtl/ser_frame_rx.sv | 51 +++++
 rtl/change_dispenser.sv | 100 ++++++++++
 3 files changed

// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM states, the coin
// denomination table and the serial frame geometry.
package change_pkg;

    localparam int AMT_W     = 8;
    localparam int IDX_W     = 3;
    localparam int CNT_W     = 4;
    localparam int FRAME_LEN = 9;

    localparam logic [AMT_W-1:0] D0 = 8'd50;
    localparam logic [AMT_W-1:0] D1 = 8'd20;
    localparam logic [AMT_W-1:0] D2 = 8'd10;
    localparam logic [AMT_W-1:0] D3 = 8'd5;
    localparam logic [AMT_W-1:0] D4 = 8'd2;
    localparam logic [AMT_W-1:0] D5 = 8'd1;

    localparam logic [IDX_W-1:0] LAST_IDX = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        SELECT,
        ISSUE,
        DONE
    } state_t;

    // Denomination lookup; the table must stay descending and end in 1.
    function automatic logic [AMT_W-1:0] denom(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    denom = D0;
            3'd1:    denom = D1;
            3'd2:    denom = D2;
            3'd3:    denom = D3;
            3'd4:    denom = D4;
            default: denom = D5;
        endcase
    endfunction

endpackage

// File: rtl/ser_frame_rx.sv
// Serial frame receiver: shifts in the MSB-first frame, counts bits and flags
// a clean close, a malformed close, or a frame that starts while paying out.
module ser_frame_rx
    import change_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_valid,
    input  logic             ser_data,
    input  logic             ser_done,
    input  logic             in_idle,
    input  logic             in_recv,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [AMT_W-1:0] data
);

    logic [AMT_W-1:0] sh;
    logic [CNT_W-1:0] cnt;
    logic             valid_q;
    logic             closing;
    logic             stray_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh      <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= ser_valid;
            if (ser_valid && in_idle) begin
                sh  <= {sh[AMT_W-2:0], ser_data};
                cnt <= CNT_W'(1);
            end else if (ser_valid && in_recv) begin
                sh <= {sh[AMT_W-2:0], ser_data};
                if (cnt != {CNT_W{1'b1}})
                    cnt <= cnt + CNT_W'(1);
            end else if (in_recv) begin
                cnt <= '0;
            end
        end
    end

    // The lead bit has been pushed out of the 8-bit register by the data bits.
    assign closing     = in_recv && !ser_valid;
    assign frame_ok    = closing && (cnt == CNT_W'(FRAME_LEN)) && ser_done;
    assign stray_start = ser_valid && !valid_q && !in_idle && !in_recv;
    assign frame_err   = (closing && !frame_ok) || stray_start;
    assign data        = sh;

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: receives the change amount as a serial frame, then pays it
// out greedily, one coin request per valid/ready handshake.
module change_dispenser
    import change_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_valid,
    input  logic             ser_data,
    input  logic             ser_done,
    input  logic             coin_rdy,
    output logic             coin_valid,
    output logic [IDX_W-1:0] coin_sel,
    output logic [AMT_W-1:0] amount_out,
    output logic             busy,
    output logic             disp_done,
    output logic             frame_err
);

    state_t           state;
    logic [AMT_W-1:0] amount;
    logic [IDX_W-1:0] idx;
    logic             rx_ok;
    logic             rx_err;
    logic [AMT_W-1:0] rx_data;

    ser_frame_rx u_rx (
        .clk       (clk),
        .rst       (rst),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_done  (ser_done),
        .in_idle   (state == IDLE),
        .in_recv   (state == RECV),
        .frame_ok  (rx_ok),
        .frame_err (rx_err),
        .data      (rx_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            amount     <= '0;
            idx        <= '0;
            coin_valid <= 1'b0;
            coin_sel   <= '0;
            disp_done  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            disp_done <= 1'b0;
            frame_err <= rx_err;
            case (state)
                IDLE: begin
                    if (ser_valid)
                        state <= RECV;
                end
                RECV: begin
                    if (rx_ok) begin
                        amount <= rx_data;
                        idx    <= '0;
                        state  <= SELECT;
                    end else if (rx_err) begin
                        state <= IDLE;
                    end
                end
                // The final denomination is 1, so idx stops advancing before it overflows.
                SELECT: begin
                    if (amount == '0) begin
                        disp_done <= 1'b1;
                        state     <= DONE;
                    end else if (amount >= denom(idx)) begin
                        coin_valid <= 1'b1;
                        coin_sel   <= idx;
                        state      <= ISSUE;
                    end else if (idx != LAST_IDX) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ISSUE: begin
                    if (coin_rdy) begin
                        amount     <= amount - denom(idx);
                        coin_valid <= 1'b0;
                        coin_sel   <= '0;
                        state      <= SELECT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign amount_out = amount;
    assign busy       = (state != IDLE);

endmodule
